// File: rtl/common_lifo_stream.sv
// -----------------------------------------------------------------------------
// common_lifo_stream
//
// Stream-interfaced LIFO buffer. Words enter on a valid/ready push port and
// leave last-in-first-out on a valid/ready pop port. The top-of-stack is held
// in a dedicated register that drives o_data. The entries below it live in an
// array whose oldest entry is at index 0. A push and a pop in the same cycle
// replace the top word and leave the rest of the stack untouched.
//
// Parameters
//   DEPTH : total capacity in words (2..4096)
//   DSIZE : data width in bits
//   CW    : count width, derived from DEPTH (do not override)
//
// Ports
//   clock   : single clock, rising edge
//   rst     : asynchronous active-high reset
//   flush   : synchronous clear of the stack contents (count only)
//   i_data  : push data
//   i_valid : push request
//   i_ready : push accept (combinational from o_ready when full)
//   o_data  : current top-of-stack
//   o_valid : top-of-stack holds a word
//   o_ready : pop accept from consumer
//   count   : number of stored words, 0..DEPTH
//   empty   : count == 0
//   full    : count == DEPTH
// -----------------------------------------------------------------------------
module common_lifo_stream #(
    parameter int DEPTH = 16,
    parameter int DSIZE = 32,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             flush,
    input  logic [DSIZE-1:0] i_data,
    input  logic             i_valid,
    output logic             i_ready,
    output logic [DSIZE-1:0] o_data,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    // Index width of the below-top array (DEPTH-1 entries, at least 1).
    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH - 1) : 1;

    logic [DSIZE-1:0] r_top;
    logic [CW-1:0]    r_count;
    logic [DSIZE-1:0] r_mem [0:DEPTH-2];

    logic             w_push;
    logic             w_pop;
    logic [AW-1:0]    w_wr_idx;
    logic [AW-1:0]    w_rd_idx;
    logic [DSIZE-1:0] w_rd_data;
    logic             w_mem_we;

    // -------------------------------------------------------------------------
    // Status decode, all from registered count.
    // -------------------------------------------------------------------------
    assign empty   = (r_count == '0);
    assign full    = (r_count == CW'(DEPTH));
    assign o_valid = !empty;
    // At full, a push is only possible when the top word leaves in the same
    // cycle, which frees exactly the slot the new word needs.
    assign i_ready = !full || o_ready;
    assign o_data  = r_top;
    assign count   = r_count;

    assign w_push  = i_valid && i_ready;
    assign w_pop   = o_valid && o_ready;

    // Push-only moves the current top into M[n-1]; pop-only pulls M[n-2] up.
    // Both indices wrap for small n, but are only used when n is large enough.
    assign w_wr_idx  = AW'(r_count - CW'(1));
    assign w_rd_idx  = AW'(r_count - CW'(2));
    assign w_rd_data = r_mem[w_rd_idx];
    assign w_mem_we  = !flush && w_push && !w_pop && !empty;

    // -------------------------------------------------------------------------
    // Top register and count.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_top   <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else begin
            unique case ({w_push, w_pop})
                2'b10: begin
                    r_top   <= i_data;
                    r_count <= r_count + CW'(1);
                end
                2'b01: begin
                    // With one word left the top simply goes stale.
                    if (r_count > CW'(1)) begin
                        r_top <= w_rd_data;
                    end
                    r_count <= r_count - CW'(1);
                end
                2'b11: begin
                    // Consumer takes the old top; the new word replaces it.
                    r_top <= i_data;
                end
                default: begin
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Below-top storage.
    // -------------------------------------------------------------------------
    // NOTE: the array has no reset; entries above count are never read, so
    // clearing them would only cost reset fan-out.
    always_ff @(posedge clock) begin
        if (w_mem_we) begin
            r_mem[w_wr_idx] <= r_top;
        end
    end

endmodule

// File: tb/tb_common_lifo_stream.sv
// -----------------------------------------------------------------------------
// tb_common_lifo_stream
//
// Directed bench for common_lifo_stream with DEPTH = 4, DSIZE = 8. Inputs are
// driven 1 ns after each rising edge; outputs are checked at the same point,
// so every check sees settled post-edge state (and combinational i_ready).
// -----------------------------------------------------------------------------
module tb_common_lifo_stream;

    localparam int DEPTH = 4;
    localparam int DSIZE = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clock;
    logic             rst;
    logic             flush;
    logic [DSIZE-1:0] i_data;
    logic             i_valid;
    logic             i_ready;
    logic [DSIZE-1:0] o_data;
    logic             o_valid;
    logic             o_ready;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    common_lifo_stream #(
        .DEPTH(DEPTH),
        .DSIZE(DSIZE)
    ) dut (
        .clock  (clock),
        .rst    (rst),
        .flush  (flush),
        .i_data (i_data),
        .i_valid(i_valid),
        .i_ready(i_ready),
        .o_data (o_data),
        .o_valid(o_valid),
        .o_ready(o_ready),
        .count  (count),
        .empty  (empty),
        .full   (full)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_one(input logic [DSIZE-1:0] d);
        i_valid = 1'b1;
        i_data  = d;
        tick();
        i_valid = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        flush   = 1'b0;
        i_data  = '0;
        i_valid = 1'b0;
        o_ready = 1'b0;
        tick();
        tick();
        #2 rst = 1'b0;
        tick();

        // ---- Reset state ----
        check("rst_count",   count,   0);
        check("rst_empty",   empty,   1);
        check("rst_full",    full,    0);
        check("rst_o_valid", o_valid, 0);
        check("rst_o_data",  o_data,  0);
        check("rst_i_ready", i_ready, 1);

        // ---- Order: push A1, A2, A3 back to back, then pop continuously ----
        i_valid = 1'b1;
        i_data  = 8'hA1; tick();
        check("ord_top1", o_data, 8'hA1);
        check("ord_cnt1", count, 1);
        check("ord_vld1", o_valid, 1);
        i_data  = 8'hA2; tick();
        check("ord_top2", o_data, 8'hA2);
        i_data  = 8'hA3; tick();
        check("ord_top3", o_data, 8'hA3);
        check("ord_cnt3", count, 3);
        i_valid = 1'b0;
        o_ready = 1'b1;
        tick();
        check("ord_pop1", o_data, 8'hA2);
        check("ord_pcnt1", count, 2);
        tick();
        check("ord_pop2", o_data, 8'hA1);
        check("ord_pcnt2", count, 1);
        tick();
        check("ord_empty", empty, 1);
        check("ord_vld0", o_valid, 0);
        check("ord_cnt0", count, 0);
        o_ready = 1'b0;

        // ---- Full: push 1..4, fifth push held off ----
        push_one(8'd1);
        push_one(8'd2);
        push_one(8'd3);
        push_one(8'd4);
        check("full_flag", full, 1);
        check("full_cnt", count, 4);
        check("full_ird", i_ready, 0);
        i_valid = 1'b1;
        i_data  = 8'd5;
        tick();
        i_valid = 1'b0;
        check("full_hold_top", o_data, 8'd4);
        check("full_hold_cnt", count, 4);

        // ---- Simultaneous push+pop at full ----
        i_valid = 1'b1;
        i_data  = 8'd9;
        o_ready = 1'b1;
        #1;
        check("sim_ird", i_ready, 1);
        check("sim_consumed", o_data, 8'd4);
        tick();
        i_valid = 1'b0;
        check("sim_top", o_data, 8'd9);
        check("sim_cnt", count, 4);
        check("sim_full", full, 1);
        tick();
        check("sim_pop3", o_data, 8'd3);
        tick();
        check("sim_pop2", o_data, 8'd2);
        tick();
        check("sim_pop1", o_data, 8'd1);
        check("sim_cnt1", count, 1);
        tick();
        check("sim_empty", empty, 1);
        o_ready = 1'b0;

        // ---- Single-entry push+pop ----
        push_one(8'h55);
        check("one_cnt", count, 1);
        i_valid = 1'b1;
        i_data  = 8'h66;
        o_ready = 1'b1;
        #1;
        check("one_consumed", o_data, 8'h55);
        tick();
        i_valid = 1'b0;
        check("one_top", o_data, 8'h66);
        check("one_cnt_hold", count, 1);
        tick();
        o_ready = 1'b0;
        check("one_empty", empty, 1);
        check("one_vld0", o_valid, 0);

        // ---- Flush with concurrent push ----
        push_one(8'h11);
        push_one(8'h22);
        push_one(8'h33);
        check("fl_cnt3", count, 3);
        flush   = 1'b1;
        i_valid = 1'b1;
        i_data  = 8'h44;
        tick();
        flush   = 1'b0;
        i_valid = 1'b0;
        check("fl_cnt0", count, 0);
        check("fl_empty", empty, 1);
        check("fl_vld0", o_valid, 0);
        push_one(8'h77);
        check("fl_cnt1", count, 1);
        check("fl_top", o_data, 8'h77);

        // ---- Asynchronous reset mid-stream ----
        push_one(8'hB2);
        push_one(8'hB3);
        check("ar_cnt3", count, 3);
        #2 rst = 1'b1;
        #1;
        check("ar_count", count, 0);
        check("ar_empty", empty, 1);
        check("ar_vld0", o_valid, 0);
        check("ar_o_data", o_data, 0);
        check("ar_ird", i_ready, 1);
        #1 rst = 1'b0;
        tick();
        push_one(8'hC1);
        check("ar_after_top", o_data, 8'hC1);
        check("ar_after_cnt", count, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/common_lifo_stream.md
# common_lifo_stream

Stream-interfaced LIFO buffer that sits downstream of the stack pointer logic in the common FIFO/stack library. It accepts words on a valid/ready push port and returns them last-in-first-out on a valid/ready pop port. The top-of-stack lives in a dedicated output register, and the remaining entries live in an array. Used wherever a producer's items must be replayed in reverse order, e.g. backtracking address lists or reversing bursts.

## Interface
- DEPTH, 16: total capacity in words; legal range 2..4096.
- DSIZE, 32: data width in bits.
- CW, $clog2(DEPTH+1): count width (derived; not to be overridden).

- clock  input  1  single clock domain; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of stack contents.
- i_data  input  DSIZE  push data.
- i_valid  input  1  push request.
- i_ready  output  1  push accept.
- o_data  output  DSIZE  current top-of-stack.
- o_valid  output  1  top-of-stack holds a word.
- o_ready  input  1  pop accept from consumer.
- count  output  CW  number of stored words, 0..DEPTH.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.

## Operation
- Storage: top register T drives o_data. Array M[0..DEPTH-2] holds the entries below the top, oldest at M[0]. With n = count, the valid array entries are M[0..n-2].
- push = i_valid && i_ready. pop = o_valid && o_ready.
- i_ready = !full || o_ready. At full, a push is accepted only together with a pop. This is a combinational path from o_ready.
- o_valid = (count != 0), derived from registered state only.
- Priority per cycle: rst > flush > push/pop.
- Push only: if n > 0, M[n-1] <= T. Then T <= i_data and n <= n+1.
- Pop only: if n > 1, T <= M[n-2]; if n == 1, T holds its value (don't-care, o_valid drops). n <= n-1. Array read is asynchronous/combinational.
- Push and pop in the same cycle: the consumer takes the old T, then T <= i_data. n and M are unchanged. This also applies at full, so the full condition holds through a simultaneous push/pop.
- Flush: n <= 0 and T is left unchanged. i_valid/o_ready in that cycle are ignored (i_ready is still computed as above, but no push takes effect).
- empty and full are decoded from registered count; no extra state.
- Pop while empty is impossible (o_valid = 0). Push while full without pop is blocked (i_ready = 0). No overflow or underflow state exists.

## Timing
- Reset values: count = 0, T (o_data) = 0, o_valid = 0, empty = 1, full = 0, i_ready = 1. Reset asserted mid-operation clears everything immediately (asynchronously); contents of M are not cleared and not needed.
- Push-to-visible latency: 1 cycle. A word accepted at edge k appears on o_data with o_valid = 1 after edge k.
- Pop-to-next latency: 1 cycle. After a pop at edge k, o_data shows the next-older word after edge k.
- Sustained throughput: one push, one pop, or one push+pop per cycle, with no bubbles.
- count, empty and full change only on clock edges (or at rst assertion).

## Test plan
- Reset: assert rst mid-stream with count = 3 -> count = 0, empty = 1, o_valid = 0, o_data = 0 without waiting for a clock edge; i_ready = 1.
- Order: DEPTH = 4; push 0xA1, 0xA2, 0xA3 on consecutive cycles, then hold o_ready = 1 -> pops 0xA3, 0xA2, 0xA1 on consecutive cycles; empty = 1 afterwards.
- Full: push 1, 2, 3, 4 -> full = 1, count = 4, i_ready = 0 while o_ready = 0. A fifth push is held off and o_data stays 4.
- Simultaneous at full: at full with o_data = 4, drive i_valid = 1, i_data = 9, o_ready = 1 -> consumer gets 4, o_data = 9, count stays 4. Then pop four times -> 9, 3, 2, 1.
- Single-entry edge: push 0x55 then push+pop together -> popped 0x55, new top = pushed word, count = 1. A following pop -> empty = 1, o_valid = 0.
- Flush: with count = 3, assert flush together with i_valid = 1 -> count = 0, empty = 1, and the push is discarded. Next push of 0x77 -> count = 1, o_data = 0x77.
